fft_twiddle_sched: RTL and testbench

FFT_TWIDDLE_SCHED -- requirements
Module: fft_twiddle_sched

---
 rtl/fft_twiddle_sched_pkg.sv | 20 ++
 rtl/fft_addr_gen.sv | 58 +++++
 rtl/fft_twiddle_sched.sv | 124 ++++++++++++
 tb/tb_fft_twiddle_sched.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_twiddle_sched_pkg.sv
// Shared constants and FSM encoding for the radix-2 128-point FFT butterfly scheduler.
package fft_twiddle_sched_pkg;

   localparam int FFT_LEN      = 128;
   localparam int N_STAGES     = $clog2(FFT_LEN);     // 7 stages of butterflies
   localparam int BF_PER_STAGE = FFT_LEN / 2;         // 64 butterflies per stage
   localparam int ADDR_W       = $clog2(FFT_LEN);     // sample address width
   localparam int TW_W         = N_STAGES - 1;        // 64-entry twiddle table index
   localparam int STAGE_W      = 3;
   localparam int K_W          = $clog2(BF_PER_STAGE);
   localparam int DRAIN_W      = 4;                   // holds PIPE_LAT up to 15

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Maps (stage, butterfly index) to registered sample addresses and twiddle index.
import fft_twiddle_sched_pkg::*;

module fft_addr_gen (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_load,
   input  logic                 i_clear,
   input  logic [STAGE_W-1:0]   i_stage,
   input  logic [K_W-1:0]       i_k,
   output logic [ADDR_W-1:0]    o_addr_a,
   output logic [ADDR_W-1:0]    o_addr_b,
   output logic [TW_W-1:0]      o_tw_idx
);

   logic [ADDR_W-1:0] w_k_ext;
   logic [ADDR_W-1:0] w_h;
   logic [ADDR_W-1:0] w_pos;
   logic [ADDR_W-1:0] w_grp;
   logic [ADDR_W-1:0] w_addr_a;
   logic [TW_W-1:0]   w_tw;

   logic [ADDR_W-1:0] r_addr_a;
   logic [ADDR_W-1:0] r_addr_b;
   logic [TW_W-1:0]   r_tw_idx;

   // Butterfly span h=2^s; upper leg sits in group grp at offset pos, lower leg h above it.
   always_comb begin
      w_k_ext  = {1'b0, i_k};
      w_h      = 7'd1 << i_stage;
      w_pos    = w_k_ext & (w_h - 7'd1);
      w_grp    = w_k_ext >> i_stage;
      w_addr_a = (w_grp << (i_stage + 3'd1)) | w_pos;
      w_tw     = w_pos[TW_W-1:0] << (3'd6 - i_stage);
   end

   // Output registers: load the next issue's addresses, clear when returning to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_tw_idx <= '0;
      end else if (i_clear) begin
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_tw_idx <= '0;
      end else if (i_load) begin
         r_addr_a <= w_addr_a;
         r_addr_b <= w_addr_a + w_h;
         r_tw_idx <= w_tw;
      end
   end

   assign o_addr_a = r_addr_a;
   assign o_addr_b = r_addr_b;
   assign o_tw_idx = r_tw_idx;

endmodule

// File: rtl/fft_twiddle_sched.sv
// Butterfly issue scheduler for a 128-point radix-2 FFT: FSM, butterfly and drain counters.
import fft_twiddle_sched_pkg::*;

module fft_twiddle_sched #(
   parameter int PIPE_LAT = 4,
   parameter int N_LOG2   = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                stall,
   output logic                ready,
   output logic                busy,
   output logic                bf_valid,
   output logic [STAGE_W-1:0]  stage,
   output logic [ADDR_W-1:0]   addr_a,
   output logic [ADDR_W-1:0]   addr_b,
   output logic [TW_W-1:0]     tw_idx,
   output logic                done
);

   localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(N_LOG2 - 1);
   localparam logic [K_W-1:0]     K_LAST     = K_W'(BF_PER_STAGE - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_LAT);

   state_t               r_state;
   state_t               w_state_next;
   logic [STAGE_W-1:0]   r_stage;
   logic [STAGE_W-1:0]   w_stage_next;
   logic [K_W-1:0]       r_k;
   logic [K_W-1:0]       w_k_next;
   logic [DRAIN_W-1:0]   r_drain;
   logic [DRAIN_W-1:0]   w_drain_next;
   logic                 w_addr_load;
   logic                 w_addr_clear;

   // State and counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_stage <= '0;
         r_k     <= '0;
         r_drain <= '0;
      end else begin
         r_state <= w_state_next;
         r_stage <= w_stage_next;
         r_k     <= w_k_next;
         r_drain <= w_drain_next;
      end
   end

   // Next-state and counter update; a stalled RUN cycle changes nothing.
   always_comb begin
      w_state_next = r_state;
      w_stage_next = r_stage;
      w_k_next     = r_k;
      w_drain_next = r_drain;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_RUN;
               w_stage_next = '0;
               w_k_next     = '0;
            end
         end
         ST_RUN: begin
            if (!stall) begin
               if (r_k == K_LAST) begin
                  w_state_next = ST_DRAIN;
                  w_drain_next = DRAIN_LOAD;
                  w_k_next     = '0;
               end else begin
                  w_k_next = r_k + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            // PIPE_LAT idle cycles let the butterfly pipeline flush before the next stage.
            w_drain_next = r_drain - 1'b1;
            if (r_drain <= 4'd1) begin
               w_drain_next = '0;
               if (r_stage == STAGE_LAST) begin
                  w_state_next = ST_DONE;
               end else begin
                  w_state_next = ST_RUN;
                  w_stage_next = r_stage + 1'b1;
                  w_k_next     = '0;
               end
            end
         end
         ST_DONE: begin
            w_state_next = ST_IDLE;
            w_stage_next = '0;
            w_k_next     = '0;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Addresses follow the (stage,k) that will be presented in the next RUN cycle.
   assign w_addr_load  = (w_state_next == ST_RUN);
   assign w_addr_clear = (w_state_next == ST_IDLE);

   fft_addr_gen u_addr_gen (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_addr_load),
      .i_clear  (w_addr_clear),
      .i_stage  (w_stage_next),
      .i_k      (w_k_next),
      .o_addr_a (addr_a),
      .o_addr_b (addr_b),
      .o_tw_idx (tw_idx)
   );

   assign ready    = (r_state == ST_IDLE);
   assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
   assign bf_valid = (r_state == ST_RUN) && !stall;
   assign done     = (r_state == ST_DONE);
   assign stage    = r_stage;

endmodule

// File: tb/tb_fft_twiddle_sched.sv
// Directed bench for fft_twiddle_sched with an independent address/twiddle model.
module tb_fft_twiddle_sched;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stall;
   logic       ready;
   logic       busy;
   logic       bf_valid;
   logic [2:0] stage;
   logic [6:0] addr_a;
   logic [6:0] addr_b;
   logic [5:0] tw_idx;
   logic       done;

   int vectors;
   int miscompares;

   // per-transform bookkeeping
   int  t;
   int  pulses;
   int  done_cnt;
   int  t_done;
   int  ready_cnt;
   int  model_bad;
   int  dup_cnt;
   bit  seen [128];

   fft_twiddle_sched #(.PIPE_LAT(4), .N_LOG2(7)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stall    (stall),
      .ready    (ready),
      .busy     (busy),
      .bf_valid (bf_valid),
      .stage    (stage),
      .addr_a   (addr_a),
      .addr_b   (addr_b),
      .tw_idx   (tw_idx),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one transform from the cycle after acceptance until the cycle after done.
   // start must already be high so the preceding edge accepts it.
   task automatic run_xfer(input int stall_at, input int stall_len, input bit keep_start);
      int es, ek, eh, ea, eb, et;
      t = 0; pulses = 0; done_cnt = 0; t_done = 0; ready_cnt = 0;
      model_bad = 0; dup_cnt = 0;
      for (int i = 0; i < 128; i++) seen[i] = 1'b0;
      while (t < 1200) begin
         @(negedge clk);
         t++;
         if (t == 1) start = keep_start;
         stall = (stall_len > 0) && (t >= stall_at) && (t < stall_at + stall_len);
         #1;
         if (t == 1) begin
            chk("first_bf_valid", bf_valid, 1);
            chk("first_stage", stage, 0);
            chk("first_addr_a", addr_a, 0);
            chk("first_addr_b", addr_b, 1);
            chk("first_tw", tw_idx, 0);
            chk("first_busy", busy, 1);
         end
         if (stall_len == 0 && t == 142) begin
            chk("s2k5_addr_a", addr_a, 9);
            chk("s2k5_addr_b", addr_b, 13);
            chk("s2k5_tw", tw_idx, 16);
         end
         if (stall_len == 0 && t == 414) begin
            chk("s6k5_addr_a", addr_a, 5);
            chk("s6k5_addr_b", addr_b, 69);
            chk("s6k5_tw", tw_idx, 5);
         end
         if (stall_len == 0 && t == 65) chk("drain_no_valid", bf_valid, 0);
         if (stall_len > 0 && (t == stall_at || t == stall_at + stall_len - 1)) begin
            chk("stall_valid", bf_valid, 0);
            chk("stall_stage", stage, 3);
            chk("stall_addr_a", addr_a, 36);
            chk("stall_addr_b", addr_b, 44);
            chk("stall_tw", tw_idx, 32);
         end
         if (stall_len > 0 && t == stall_at + stall_len) begin
            chk("unstall_valid", bf_valid, 1);
            chk("unstall_addr_a", addr_a, 36);
         end
         if (bf_valid) begin
            es = pulses / 64;
            ek = pulses % 64;
            eh = 1 << es;
            ea = (ek / eh) * 2 * eh + (ek % eh);
            eb = ea + eh;
            et = ((ek % eh) * (64 / eh)) % 64;
            if (ek == 0) for (int i = 0; i < 128; i++) seen[i] = 1'b0;
            if (es > 6 || stage != es[2:0] || addr_a != ea[6:0] || addr_b != eb[6:0]
                || tw_idx != et[5:0]) model_bad++;
            if (es <= 6) begin
               if (seen[ea[6:0]]) dup_cnt++;
               seen[ea[6:0]] = 1'b1;
            end
            pulses++;
         end
         if (done) begin
            done_cnt++;
            t_done = t;
         end
         if (done_cnt > 0 && t == t_done + 1) begin
            chk("ready_after_done", ready, 1);
            chk("done_one_cycle", done, 0);
            break;
         end
         if (ready) ready_cnt++;
      end
      $display("xfer: stall_len=%0d pulses=%0d done_at=%0d dones=%0d", stall_len, pulses, t_done, done_cnt);
      chk("pulse_count", pulses, 448);
      chk("done_count", done_cnt, 1);
      chk("done_latency", t_done, 477 + stall_len);
      chk("ready_during_run", ready_cnt, 0);
      chk("addr_model", model_bad, 0);
      chk("pair_unique", dup_cnt, 0);
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; start = 1'b0; stall = 1'b0;

      // reset state
      @(negedge clk); @(negedge clk);
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", bf_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_stage", stage, 0);
      chk("rst_addr_a", addr_a, 0);
      chk("rst_addr_b", addr_b, 0);
      chk("rst_tw", tw_idx, 0);
      $display("reset: ready=%0b busy=%0b", ready, busy);

      // unstalled transform
      rst = 1'b0;
      @(negedge clk);
      chk("idle_ready", ready, 1);
      chk("idle_addr_b", addr_b, 0);
      start = 1'b1;
      run_xfer(0, 0, 1'b0);

      // 10-cycle stall at stage 3, k=20 (t = 3*68 + 1 + 20)
      @(negedge clk);
      start = 1'b1;
      run_xfer(225, 10, 1'b0);

      // abort at stage 4, k=30 (t = 4*68 + 1 + 30)
      @(negedge clk);
      start = 1'b1;
      for (int i = 1; i <= 303; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
      end
      #1;
      chk("pre_abort_stage", stage, 4);
      chk("pre_abort_addr_a", addr_a, 46);
      chk("pre_abort_addr_b", addr_b, 62);
      chk("pre_abort_tw", tw_idx, 56);
      rst = 1'b1;
      #1;
      chk("abort_ready", ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_valid", bf_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_stage", stage, 0);
      chk("abort_addr_a", addr_a, 0);
      chk("abort_addr_b", addr_b, 0);
      chk("abort_tw", tw_idx, 0);
      $display("abort: stage=%0d addr_a=%0d", stage, addr_a);
      @(negedge clk);
      chk("abort_no_done", done, 0);

      // restart straight after deassert, start held high: two back-to-back transforms
      rst = 1'b0;
      start = 1'b1;
      run_xfer(0, 0, 1'b1);
      run_xfer(0, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
